// File: rtl/bench_bist_pkg.sv
// Shared types and constants for the benchmark BIST response path.
package bench_bist_pkg;

    // Compactor sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Port widths of the combinational benchmark circuit under test.
    localparam int BENCH_OUT_W = 25;
    localparam int BENCH_IN_W  = 33;

    // x^25 + x^3 + 1: feedback from bit 24 lands on bits 3 and 0.
    localparam logic [BENCH_OUT_W-1:0] DEFAULT_POLY = 25'h0000009;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: shift left, fold the MSB back through
// the tap mask, then XOR in the parallel input word.
module misr_core #(
    parameter int               WIDTH = 25,
    parameter logic [WIDTH-1:0] POLY  = 25'h0000009
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;

    // Next signature for one compaction step.
    always_comb begin
        q_next = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? POLY : '0) ^ d;
    end

    // Signature register; clear takes priority over a compaction step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/bench_resp_misr.sv
// Response compactor: folds N benchmark output vectors into a MISR and
// compares the final signature against a golden value.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, signature/count cleared
// ST_RUN   | resp_ready high, compacting one vector per accept
// ST_CHECK | single cycle, pass <= (signature == golden)
// ST_DONE  | done high, signature/pass/count held until start or abort
module bench_resp_misr
    import bench_bist_pkg::*;
#(
    parameter int               WIDTH = BENCH_OUT_W,
    parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             ready_q;
    logic             pass_q;
    logic             start_acc;
    logic             accept;
    logic             last_accept;
    logic             misr_clr;

    assign cnt_inc = count_q + CNT_ONE;

    // Handshake qualification; abort suppresses both start and accept.
    always_comb begin
        start_acc   = start & ~abort &
                      ((state_q == ST_IDLE) || (state_q == ST_DONE));
        accept      = resp_valid & ready_q & ~abort;
        last_accept = accept & (cnt_inc == n_q);
        misr_clr    = abort | start_acc;
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    state_d = (num_patterns == '0) ? ST_CHECK : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_accept) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // State register plus registered ready so resp_ready has no path from resp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_RUN);
        end
    end

    // Pattern budget latch and accepted-vector counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q     <= '0;
            count_q <= '0;
        end else if (abort) begin
            count_q <= '0;
        end else if (start_acc) begin
            n_q     <= num_patterns;
            count_q <= '0;
        end else if (accept) begin
            count_q <= cnt_inc;
        end
    end

    // Verdict register, written only in the single CHECK cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
        end else if (misr_clr) begin
            pass_q <= 1'b0;
        end else if (state_q == ST_CHECK) begin
            pass_q <= (signature == golden);
        end
    end

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (accept),
        .d     (resp_data),
        .q     (signature)
    );

    assign resp_ready = ready_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign count      = count_q;

endmodule

// File: tb/tb_bench_resp_misr.sv
// Self-checking bench for the benchmark response compactor.
module tb_bench_resp_misr;

    localparam int W = 25;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [C-1:0] num_patterns = '0;
    logic [W-1:0] golden = '0;
    logic         resp_valid = 1'b0;
    logic [W-1:0] resp_data = '0;
    logic         resp_ready;
    logic         busy;
    logic         done;
    logic         pass;
    logic [W-1:0] signature;
    logic [C-1:0] count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] sig;
        logic         pass;
        logic [C-1:0] cnt;
    } exp_t;

    typedef struct {
        logic [C-1:0]         n;
        logic [3:0][W-1:0]    data;
        logic [W-1:0]         golden;
        logic [W-1:0]         exp_sig;
        logic                 exp_pass;
    } vec_t;

    exp_t sb_q[$];

    bench_resp_misr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .num_patterns (num_patterns),
        .golden       (golden),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_step(input logic [W-1:0] s, input logic [W-1:0] d);
        logic         fb;
        logic [W-1:0] r;
        fb = s[W-1];
        r  = s << 1;
        if (fb) begin
            r[0] = ~r[0];
            r[3] = ~r[3];
        end
        return r ^ d;
    endfunction

    // Start a run, stream n vectors back-to-back, wait for done, score it.
    task automatic run_vec(input logic [C-1:0] n, input logic [15:0][W-1:0] d,
                           input logic [W-1:0] gold, input exp_t e, input string name);
        int   acc;
        int   cyc;
        exp_t got;
        golden       = gold;
        num_patterns = n;
        start        = 1'b1;
        sb_q.push_back(e);
        tick();
        start = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < int'(n) && cyc < 200) begin
            resp_valid = 1'b1;
            resp_data  = d[acc];
            if (resp_ready) acc++;
            tick();
            cyc++;
        end
        resp_valid = 1'b0;
        resp_data  = '0;
        check({name, "_accepts"}, acc, int'(n));
        cyc = 0;
        while (!done && cyc < 10) begin
            tick();
            cyc++;
        end
        check({name, "_done"}, done, 1);
        got = sb_q.pop_front();
        check({name, "_sig"}, signature, got.sig);
        check({name, "_pass"}, pass, got.pass);
        check({name, "_count"}, count, got.cnt);
        check({name, "_busy"}, busy, 0);
        check({name, "_ready"}, resp_ready, 0);
    endtask

    initial begin
        vec_t             tbl[6];
        exp_t             e;
        logic [15:0][W-1:0] d;
        logic [W-1:0]     m;
        logic [W-1:0]     junk;
        int               n_acc;
        int               ready_seen;
        logic [5:0]       vpat;

        tbl[0] = '{n: 16'd1, data: {25'h0, 25'h0, 25'h0, 25'h0000001},
                   golden: 25'h0000001, exp_sig: 25'h0000001, exp_pass: 1'b1};
        tbl[1] = '{n: 16'd2, data: {25'h0, 25'h0, 25'h0000000, 25'h1000000},
                   golden: 25'h0000009, exp_sig: 25'h0000009, exp_pass: 1'b1};
        tbl[2] = '{n: 16'd2, data: {25'h0, 25'h0, 25'h0000000, 25'h1000000},
                   golden: 25'h0000008, exp_sig: 25'h0000009, exp_pass: 1'b0};
        tbl[3] = '{n: 16'd0, data: {25'h0, 25'h0, 25'h0, 25'h0},
                   golden: 25'h0000000, exp_sig: 25'h0000000, exp_pass: 1'b1};
        tbl[4] = '{n: 16'd3, data: {25'h0, 25'h0000004, 25'h0000002, 25'h0000001},
                   golden: 25'h0000004, exp_sig: 25'h0000004, exp_pass: 1'b1};
        tbl[5] = '{n: 16'd4, data: {25'h1000000, 25'h1000000, 25'h1000000, 25'h1000000},
                   golden: 25'h100003F, exp_sig: 25'h100003F, exp_pass: 1'b1};

        // Reset state
        #12;
        check("rst_sig", signature, 0);
        check("rst_count", count, 0);
        check("rst_ready", resp_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven runs
        for (int i = 0; i < 6; i++) begin
            d = '0;
            for (int j = 0; j < 4; j++) d[j] = tbl[i].data[j];
            e = '{sig: tbl[i].exp_sig, pass: tbl[i].exp_pass, cnt: tbl[i].n};
            run_vec(tbl[i].n, d, tbl[i].golden, e, $sformatf("vec%0d", i));
        end

        // Random runs against the reference model
        for (int r = 0; r < 4; r++) begin
            int nn;
            nn = $urandom_range(1, 12);
            m  = '0;
            d  = '0;
            for (int j = 0; j < nn; j++) begin
                d[j] = W'($urandom);
                m    = model_step(m, d[j]);
            end
            e = '{sig: m, pass: (r % 2 == 0), cnt: C'(nn)};
            run_vec(C'(nn), d, (r % 2 == 0) ? m : (m ^ 25'h0000100), e, $sformatf("rnd%0d", r));
        end

        // Toggled valid, N=4: garbage on idle cycles must be ignored
        golden       = 25'h100003F;
        num_patterns = 16'd4;
        start        = 1'b1;
        tick();
        start = 1'b0;
        vpat  = 6'b110101;
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            resp_valid = vpat[k];
            resp_data  = vpat[k] ? 25'h1000000 : 25'h1FFFFFF;
            if (resp_valid && resp_ready) n_acc++;
            tick();
        end
        resp_valid = 1'b0;
        check("tog_accepts", n_acc, 4);
        check("tog_check_busy", busy, 1);
        check("tog_check_done", done, 0);
        tick();
        check("tog_done", done, 1);
        check("tog_busy_drop", busy, 0);
        check("tog_count", count, 4);
        check("tog_sig", signature, 25'h100003F);
        check("tog_pass", pass, 1);

        // Abort together with the 2nd accept and a start, N=3
        golden       = 25'h0;
        num_patterns = 16'd3;
        start        = 1'b1;
        tick();
        start      = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 25'h0000001;
        tick();
        check("abt_sig_mid", signature, 25'h0000001);
        resp_data = 25'h0000005;
        abort     = 1'b1;
        start     = 1'b1;
        tick();
        abort      = 1'b0;
        start      = 1'b0;
        resp_valid = 1'b0;
        check("abt_sig", signature, 0);
        check("abt_count", count, 0);
        check("abt_ready", resp_ready, 0);
        check("abt_busy", busy, 0);
        tick();
        check("abt_stay_idle", busy | resp_ready | done, 0);

        // Async reset mid-RUN with count=3
        num_patterns = 16'd5;
        start        = 1'b1;
        tick();
        start      = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 25'h0000003;
        for (int k = 0; k < 3; k++) tick();
        check("mid_count", count, 3);
        resp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_sig", signature, 0);
        check("arst_count", count, 0);
        check("arst_ready", resp_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_done_pass", done | pass, 0);
        #2;
        rst_n = 1'b1;
        tick();

        // N=0 timing, no resp_ready pulse, then restart from DONE
        golden       = 25'h0;
        num_patterns = 16'd0;
        start        = 1'b1;
        ready_seen   = 0;
        tick();
        start = 1'b0;
        if (resp_ready) ready_seen++;
        check("n0_edge1_done", done, 0);
        check("n0_edge1_busy", busy, 1);
        tick();
        if (resp_ready) ready_seen++;
        check("n0_edge2_done", done, 1);
        check("n0_pass", pass, 1);
        check("n0_no_ready", ready_seen, 0);
        junk = 25'h0ABCDEF;
        d    = '0;
        d[0] = junk;
        e    = '{sig: junk, pass: 1'b0, cnt: 16'd1};
        run_vec(16'd1, d, 25'h0, e, "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
